// File: rtl/jk_pkg.sv
// Shared constants for the JK-based counter family: operation modes and
// the {J,K} excitation codes understood by a single JK cell.
package jk_pkg;

    // Operation select for jk_mod_counter
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // {J,K} excitation codes
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit, updated on the falling clock edge, with an
// asynchronous active-low clear and a complementary output.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic q_q;
    logic q_d;

    // Characteristic equation of the JK bit, selected by the {J,K} code
    always_comb begin
        // NOTE: default first so every path assigns q_d and no latch is inferred.
        q_d = q_q;
        case ({j, k})
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    // State register: falling edge, asynchronous clear
    always_ff @(negedge clk or negedge reset_n) begin
        // NOTE: non-blocking so all cells sample the old state on the same edge.
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS counter built from WIDTH JK cells in toggle excitation.
// The next value is computed as a binary number, and each cell is told to
// toggle exactly where that value differs from the current count.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qnot,
    output logic             tc,
    output logic             wrapped,
    output logic             load_err
);

    // Refuse to elaborate with a width or modulus the counter cannot honour
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
        $error("jk_mod_counter: WIDTH must be 1..16 and MODULUS 2..2**WIDTH");
    end

    // Highest legal count; MODULUS-1 always fits in WIDTH bits.
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
    // MODULUS itself may equal 2**WIDTH, so the range test needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] toggle;
    logic             wrapped_d;
    logic             load_err_d;
    logic             wrapped_q;
    logic             load_err_q;

    // Next count value plus the wrap/clamp events it implies
    always_comb begin
        n          = Q;
        wrapped_d  = 1'b0;
        load_err_d = 1'b0;
        if (en) begin
            case (mode)
                MODE_UP: begin
                    if (Q == Q_MAX) begin
                        n         = '0;
                        wrapped_d = 1'b1;
                    end else begin
                        n = Q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (Q == '0) begin
                        n         = Q_MAX;
                        wrapped_d = 1'b1;
                    end else begin
                        n = Q - 1'b1;
                    end
                end
                MODE_LOAD: begin
                    if ({1'b0, load_val} >= MOD_EXT) begin
                        n          = Q_MAX;
                        load_err_d = 1'b1;
                    end else begin
                        n = load_val;
                    end
                end
                default: n = Q;
            endcase
        end
    end

    // Toggle excitation: J = K = 1 only on bits that must change
    assign toggle = Q ^ n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .j       (toggle[i]),
            .k       (toggle[i]),
            .q       (Q[i]),
            .qn      (Qnot[i])
        );
    end

    // One-cycle event flags, registered alongside the count
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
        end
    end

    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;

    // Terminal count: the next counting edge will wrap
    assign tc = en & (((mode == MODE_UP) & (Q == Q_MAX)) |
                      ((mode == MODE_DOWN) & (Q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a WIDTH=4/MODULUS=10 instance and a full-range
// WIDTH=3/MODULUS=8 instance, each checked every cycle against an
// arithmetic model, plus directed literal expectations.
module tb_jk_mod_counter;
    import jk_pkg::*;

    logic       clk = 1'b1;
    logic       reset_n = 1'b1;

    logic       a_en = 1'b0;
    logic [1:0] a_mode = MODE_HOLD;
    logic [3:0] a_lv = '0;
    logic [3:0] a_q, a_qn;
    logic       a_tc, a_wr, a_le;

    logic       b_en = 1'b0;
    logic [1:0] b_mode = MODE_HOLD;
    logic [2:0] b_lv = '0;
    logic [2:0] b_q, b_qn;
    logic       b_tc, b_wr, b_le;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int ma = 0, mb = 0;
    bit mwa = 0, mla = 0, mwb = 0, mlb = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_a (
        .clk(clk), .reset_n(reset_n), .en(a_en), .mode(a_mode), .load_val(a_lv),
        .Q(a_q), .Qnot(a_qn), .tc(a_tc), .wrapped(a_wr), .load_err(a_le)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_b (
        .clk(clk), .reset_n(reset_n), .en(b_en), .mode(b_mode), .load_val(b_lv),
        .Q(b_q), .Qnot(b_qn), .tc(b_tc), .wrapped(b_wr), .load_err(b_le)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_next(input int q, input bit e, input logic [1:0] m,
                                       input int lv, input int md,
                                       output int nq, output bit w, output bit le);
        nq = q; w = 0; le = 0;
        if (e) begin
            if (m == MODE_UP) begin
                nq = (q + 1) % md; w = (q == md - 1);
            end else if (m == MODE_DOWN) begin
                nq = (q + md - 1) % md; w = (q == 0);
            end else if (m == MODE_LOAD) begin
                if (lv >= md) begin nq = md - 1; le = 1; end
                else nq = lv;
            end
        end
    endfunction

    function automatic bit model_tc(input int q, input bit e, input logic [1:0] m, input int md);
        return e && ((m == MODE_UP && q == md - 1) || (m == MODE_DOWN && q == 0));
    endfunction

    // Model advances on the same falling edge as the DUT, clears with reset
    always @(negedge clk or negedge reset_n) begin
        int na, nb;
        bit wa, la, wb, lb;
        if (!reset_n) begin
            ma = 0; mb = 0; mwa = 0; mla = 0; mwb = 0; mlb = 0;
        end else begin
            model_next(ma, a_en, a_mode, int'(a_lv), 10, na, wa, la);
            model_next(mb, b_en, b_mode, int'(b_lv), 8, nb, wb, lb);
            ma = na; mwa = wa; mla = la;
            mb = nb; mwb = wb; mlb = lb;
        end
    end

    // Every rising edge: compare all outputs of both instances with the model
    always @(posedge clk) begin
        check("a_q", int'(a_q), ma);
        check("a_qnot", int'(a_qn), int'(~a_q) & 15);
        check("a_qnot_model", int'(a_qn), (~ma) & 15);
        check("a_range", int'(a_q < 4'd10), 1);
        check("a_tc", int'(a_tc), int'(model_tc(ma, a_en, a_mode, 10)));
        check("a_wrapped", int'(a_wr), int'(mwa));
        check("a_load_err", int'(a_le), int'(mla));
        check("b_q", int'(b_q), mb);
        check("b_qnot", int'(b_qn), (~mb) & 7);
        check("b_tc", int'(b_tc), int'(model_tc(mb, b_en, b_mode, 8)));
        check("b_wrapped", int'(b_wr), int'(mwb));
        check("b_load_err", int'(b_le), int'(mlb));
    end

    task automatic drive_a(input bit e, input logic [1:0] m, input logic [3:0] lv);
        a_en = e; a_mode = m; a_lv = lv;
        #1;
    endtask

    task automatic drive_b(input bit e, input logic [1:0] m, input logic [2:0] lv);
        b_en = e; b_mode = m; b_lv = lv;
        #1;
    endtask

    // Wait for the next update edge, then settle
    task automatic edge_step();
        @(negedge clk);
        #2;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        @(negedge clk); #2;
        check("rst_q", int'(a_q), 0);
        check("rst_wrapped", int'(a_wr), 0);
        check("rst_load_err", int'(a_le), 0);
        reset_n = 1'b1;

        // Count up to 7, then reset between edges
        drive_a(1, MODE_UP, 4'd0);
        repeat (7) edge_step();
        check("up_to_7", int'(a_q), 7);
        reset_n = 1'b0;
        #1;
        check("async_rst_q", int'(a_q), 0);
        check("async_rst_wr", int'(a_wr), 0);
        check("async_rst_le", int'(a_le), 0);
        reset_n = 1'b1;
        edge_step();
        check("resume_q", int'(a_q), 1);

        // UP wrap 9 -> 0
        repeat (8) edge_step();
        check("up_at_9", int'(a_q), 9);
        check("up_tc", int'(a_tc), 1);
        edge_step();
        check("up_wrap_q", int'(a_q), 0);
        check("up_wrap_pulse", int'(a_wr), 1);
        edge_step();
        check("up_after_q", int'(a_q), 1);
        check("up_after_wr", int'(a_wr), 0);

        // DOWN wrap 0 -> 9 -> 8
        drive_a(1, MODE_DOWN, 4'd0);
        edge_step();
        check("dn_at_0", int'(a_q), 0);
        check("dn_tc", int'(a_tc), 1);
        edge_step();
        check("dn_wrap_q", int'(a_q), 9);
        check("dn_wrap_pulse", int'(a_wr), 1);
        edge_step();
        check("dn_after_q", int'(a_q), 8);
        check("dn_after_wr", int'(a_wr), 0);

        // LOAD in range and clamped
        drive_a(1, MODE_LOAD, 4'd5);
        check("load_tc", int'(a_tc), 0);
        edge_step();
        check("load5_q", int'(a_q), 5);
        check("load5_err", int'(a_le), 0);
        drive_a(1, MODE_LOAD, 4'd12);
        edge_step();
        check("load12_q", int'(a_q), 9);
        check("load12_err", int'(a_le), 1);
        drive_a(1, MODE_HOLD, 4'd0);
        edge_step();
        check("hold_q", int'(a_q), 9);
        check("hold_err_clear", int'(a_le), 0);

        // Enable low with UP at terminal value, then HOLD
        drive_a(0, MODE_UP, 4'd0);
        check("en0_tc", int'(a_tc), 0);
        repeat (3) edge_step();
        check("en0_q", int'(a_q), 9);
        check("en0_wr", int'(a_wr), 0);
        drive_a(1, MODE_HOLD, 4'd0);
        check("hold_tc", int'(a_tc), 0);
        repeat (2) edge_step();
        check("hold2_q", int'(a_q), 9);

        // Mode change with no dead cycle: load 3, UP -> 4, DOWN -> 3
        drive_a(1, MODE_LOAD, 4'd3);
        edge_step();
        drive_a(1, MODE_UP, 4'd0);
        edge_step();
        check("chg_up", int'(a_q), 4);
        drive_a(1, MODE_DOWN, 4'd0);
        edge_step();
        check("chg_dn", int'(a_q), 3);

        // Load boundaries: MODULUS clamps, MODULUS-1 does not
        drive_a(1, MODE_LOAD, 4'd10);
        edge_step();
        check("load10_q", int'(a_q), 9);
        check("load10_err", int'(a_le), 1);
        drive_a(1, MODE_LOAD, 4'd9);
        edge_step();
        check("load9_q", int'(a_q), 9);
        check("load9_err", int'(a_le), 0);
        drive_a(1, MODE_LOAD, 4'd15);
        edge_step();
        check("load15_q", int'(a_q), 9);
        check("load15_err", int'(a_le), 1);
        drive_a(0, MODE_HOLD, 4'd0);

        // Full-range instance: 7 is legal, UP from 7 overflows to 0
        drive_b(1, MODE_LOAD, 3'd7);
        edge_step();
        check("b_load7_q", int'(b_q), 7);
        check("b_load7_err", int'(b_le), 0);
        drive_b(1, MODE_UP, 3'd0);
        check("b_up_tc", int'(b_tc), 1);
        edge_step();
        check("b_wrap_q", int'(b_q), 0);
        check("b_wrap_pulse", int'(b_wr), 1);
        edge_step();
        check("b_up1_q", int'(b_q), 1);
        check("b_up1_wr", int'(b_wr), 0);
        drive_b(1, MODE_DOWN, 3'd0);
        repeat (2) edge_step();
        check("b_dn_wrap_q", int'(b_q), 7);
        check("b_dn_wrap_pulse", int'(b_wr), 1);

        // Mixed traffic on both instances, checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            a_en = ($urandom_range(0, 3) != 0);
            a_mode = 2'($urandom_range(0, 3));
            a_lv = 4'($urandom_range(0, 15));
            b_en = ($urandom_range(0, 3) != 0);
            b_mode = 2'($urandom_range(0, 3));
            b_lv = 3'($urandom_range(0, 7));
            edge_step();
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
